// File: rtl/bram_loader_pkg.sv
// rtl/bram_loader_pkg.sv - shared loader constants: frame header, target codes, FSM states
package bram_loader_pkg;

   localparam int LOADER_DATA_WIDTH = 32;

   localparam logic [7:0] HEADER_BYTE = 8'hA5;

   localparam logic [7:0] TGT_INSTR = 8'h00;
   localparam logic [7:0] TGT_DATA  = 8'h01;
   localparam logic [7:0] TGT_RUN   = 8'h02;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TARGET  = 3'd1,
      ST_CNT_LO  = 3'd2,
      ST_CNT_HI  = 3'd3,
      ST_PAYLOAD = 3'd4,
      ST_CHECK   = 3'd5,
      ST_ERROR   = 3'd6
   } loader_state_t;

endpackage

// File: rtl/bram_loader_word_assembler.sv
// rtl/bram_loader_word_assembler.sv - little-endian byte-to-word shift-in with word_valid pulse
module bram_loader_word_assembler #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_in,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_valid
);

   logic [1:0]            byte_cnt;
   logic [DATA_WIDTH-9:0] shift_q;

   // The fourth byte is used straight from the input so the word is ready in the same cycle.
   assign word       = {byte_in, shift_q};
   assign word_valid = byte_valid && (byte_cnt == 2'd3);

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         byte_cnt <= 2'd0;
         shift_q  <= '0;
      end else if (byte_valid) begin
         byte_cnt <= byte_cnt + 2'd1;
         shift_q  <= {byte_in, shift_q[DATA_WIDTH-9:8]};
      end
   end

endmodule

// File: rtl/bram_loader.sv
// rtl/bram_loader.sv - host-link frame parser loading instruction/data BRAMs and releasing the core
module bram_loader
   import bram_loader_pkg::*;
#(
   parameter int DATA_WIDTH = LOADER_DATA_WIDTH,
   parameter int ADDR_WIDTH = 10,
   parameter int MAX_WORDS  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_byte,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic [ADDR_WIDTH-1:0] i_w_addr,
   output logic [DATA_WIDTH-1:0] i_w_dat,
   output logic                  i_w_enb,
   output logic [ADDR_WIDTH-1:0] d_w_addr,
   output logic [DATA_WIDTH-1:0] d_w_dat,
   output logic                  d_w_enb,
   output logic                  cpu_stall,
   output logic                  load_done,
   output logic                  err,
   input  logic                  err_clr
);

   localparam int IDX_W = $clog2(MAX_WORDS);

   loader_state_t         state;
   logic [1:0]            target;
   logic [15:0]           count;
   logic [7:0]            csum;
   logic [IDX_W-1:0]      word_index;
   logic [DATA_WIDTH-1:0] word;
   logic                  word_valid;

   logic                  hs;
   logic                  asm_clear;
   logic                  asm_shift;
   logic [15:0]           count_full;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic                  last_word;

   assign hs         = rx_valid && rx_ready;
   assign asm_clear  = hs && (state == ST_IDLE) && (rx_byte == HEADER_BYTE);
   assign asm_shift  = hs && (state == ST_PAYLOAD);
   assign count_full = {rx_byte, count[7:0]};
   assign word_addr  = ADDR_WIDTH'({word_index, 2'b00});
   assign last_word  = (16'(word_index) + 16'd1) == count;

   bram_loader_word_assembler #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_word_assembler (
      .clk        (clk),
      .rst        (rst),
      .clear      (asm_clear),
      .byte_valid (asm_shift),
      .byte_in    (rx_byte),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         target     <= 2'd0;
         count      <= '0;
         csum       <= '0;
         word_index <= '0;
         rx_ready   <= 1'b0;
         i_w_addr   <= '0;
         i_w_dat    <= '0;
         i_w_enb    <= 1'b0;
         d_w_addr   <= '0;
         d_w_dat    <= '0;
         d_w_enb    <= 1'b0;
         cpu_stall  <= 1'b1;
         load_done  <= 1'b0;
         err        <= 1'b0;
      end else begin
         i_w_enb  <= 1'b0;
         d_w_enb  <= 1'b0;
         // Error entries below override this; ERROR keeps the link closed until err_clr.
         rx_ready <= (state != ST_ERROR);
         case (state)
            ST_IDLE: begin
               if (hs && rx_byte == HEADER_BYTE) begin
                  state      <= ST_TARGET;
                  cpu_stall  <= 1'b1;
                  load_done  <= 1'b0;
                  count      <= '0;
                  csum       <= '0;
                  word_index <= '0;
               end
            end
            ST_TARGET: begin
               if (hs) begin
                  if (rx_byte > TGT_RUN) begin
                     state    <= ST_ERROR;
                     rx_ready <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     target <= rx_byte[1:0];
                     csum   <= rx_byte;
                     state  <= ST_CNT_LO;
                  end
               end
            end
            ST_CNT_LO: begin
               if (hs) begin
                  count[7:0] <= rx_byte;
                  csum       <= csum ^ rx_byte;
                  state      <= ST_CNT_HI;
               end
            end
            ST_CNT_HI: begin
               if (hs) begin
                  count <= count_full;
                  csum  <= csum ^ rx_byte;
                  if (count_full > 16'(MAX_WORDS) ||
                      (target == TGT_RUN[1:0] && count_full != 16'd0)) begin
                     state    <= ST_ERROR;
                     rx_ready <= 1'b0;
                     err      <= 1'b1;
                  end else if (count_full == 16'd0) begin
                     state <= ST_CHECK;
                  end else begin
                     state <= ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (hs) begin
                  csum <= csum ^ rx_byte;
                  if (word_valid) begin
                     if (target == TGT_INSTR[1:0]) begin
                        i_w_enb  <= 1'b1;
                        i_w_addr <= word_addr;
                        i_w_dat  <= word;
                     end else begin
                        d_w_enb  <= 1'b1;
                        d_w_addr <= word_addr;
                        d_w_dat  <= word;
                     end
                     word_index <= word_index + 1'b1;
                     if (last_word) begin
                        state <= ST_CHECK;
                     end
                  end
               end
            end
            ST_CHECK: begin
               if (hs) begin
                  if (rx_byte == csum) begin
                     state <= ST_IDLE;
                     if (target == TGT_RUN[1:0]) begin
                        cpu_stall <= 1'b0;
                        load_done <= 1'b1;
                     end
                  end else begin
                     state    <= ST_ERROR;
                     rx_ready <= 1'b0;
                     err      <= 1'b1;
                  end
               end
            end
            ST_ERROR: begin
               if (err_clr) begin
                  state    <= ST_IDLE;
                  err      <= 1'b0;
                  rx_ready <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_loader.sv
// tb/tb_bram_loader.sv - randomized frame stimulus checked every cycle against a frame-level model
module tb_bram_loader;

   typedef logic [7:0] bq_t[$];
   typedef struct {
      bit          port;
      logic [9:0]  addr;
      logic [31:0] dat;
   } wr_t;

   localparam int MAXW = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_valid = 1'b0;
   logic        err_clr = 1'b0;
   logic        rx_ready;
   logic [9:0]  i_w_addr, d_w_addr;
   logic [31:0] i_w_dat, d_w_dat;
   logic        i_w_enb, d_w_enb, cpu_stall, load_done, err;

   bram_loader dut (
      .clk       (clk),
      .rst       (rst),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .i_w_addr  (i_w_addr),
      .i_w_dat   (i_w_dat),
      .i_w_enb   (i_w_enb),
      .d_w_addr  (d_w_addr),
      .d_w_dat   (d_w_dat),
      .d_w_enb   (d_w_enb),
      .cpu_stall (cpu_stall),
      .load_done (load_done),
      .err       (err),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   bit          chk_en = 1'b0;
   logic        exp_ready, exp_err, exp_stall, exp_done, exp_i_en, exp_d_en;
   logic [9:0]  exp_i_addr, exp_d_addr;
   logic [31:0] exp_i_dat, exp_d_dat;
   wr_t         wlog[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("rx_ready", 32'(rx_ready), 32'(exp_ready));
         check("err", 32'(err), 32'(exp_err));
         check("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
         check("load_done", 32'(load_done), 32'(exp_done));
         check("i_w_enb", 32'(i_w_enb), 32'(exp_i_en));
         check("d_w_enb", 32'(d_w_enb), 32'(exp_d_en));
         check("i_w_addr", 32'(i_w_addr), 32'(exp_i_addr));
         check("i_w_dat", i_w_dat, exp_i_dat);
         check("d_w_addr", 32'(d_w_addr), 32'(exp_d_addr));
         check("d_w_dat", d_w_dat, exp_d_dat);
         if (i_w_enb) wlog.push_back('{1'b0, i_w_addr, i_w_dat});
         if (d_w_enb) wlog.push_back('{1'b1, d_w_addr, d_w_dat});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      exp_i_en = 1'b0;
      exp_d_en = 1'b0;
   endtask

   task automatic set_err();
      exp_err   = 1'b1;
      exp_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      rx_valid = 1'b0;
      step();
      exp_ready = 1'b0; exp_err = 1'b0; exp_stall = 1'b1; exp_done = 1'b0;
      exp_i_addr = '0; exp_i_dat = '0; exp_d_addr = '0; exp_d_dat = '0;
      chk_en = 1'b1;
      rst = 1'b1;
      step();
      exp_ready = 1'b1;
   endtask

   task automatic send_clr();
      err_clr = 1'b1;
      step();
      err_clr   = 1'b0;
      exp_err   = 1'b0;
      exp_ready = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
      int w = 0;
      repeat (gap) step();
      rx_byte  = b;
      rx_valid = 1'b1;
      while (!rx_ready && w < 20) begin
         step();
         w++;
      end
      ok = rx_ready;
      if (!ok) begin
         n_total++;
         $display("FAIL handshake_timeout: rx_ready got 0 want 1 at %0t", $time);
      end else begin
         step();
      end
      rx_valid = 1'b0;
   endtask

   // Model: what each accepted byte of a frame implies, by its position in the frame.
   task automatic send_frame(input bq_t q, input int gap_lo, input int gap_hi);
      int          cnt = 0;
      int          gap;
      bit          ok;
      logic [7:0]  x;
      logic [31:0] wd;
      logic [9:0]  wa;
      for (int k = 0; k < q.size(); k++) begin
         gap = int'($urandom_range(gap_hi, gap_lo));
         send_byte(q[k], gap, ok);
         if (!ok) return;
         if (k == 0) begin
            exp_stall = 1'b1;
            exp_done  = 1'b0;
         end else if (k == 1) begin
            if (q[1] > 8'h02) begin set_err(); return; end
         end else if (k == 3) begin
            cnt = int'({q[3], q[2]});
            if (cnt > MAXW || (q[1] == 8'h02 && cnt != 0)) begin set_err(); return; end
         end else if (k >= 4 && k < 4 + 4 * cnt) begin
            if ((k - 4) % 4 == 3) begin
               wd = {q[k], q[k-1], q[k-2], q[k-3]};
               wa = 10'(((k - 4) / 4) * 4);
               if (q[1] == 8'h00) begin
                  exp_i_en = 1'b1; exp_i_addr = wa; exp_i_dat = wd;
               end else begin
                  exp_d_en = 1'b1; exp_d_addr = wa; exp_d_dat = wd;
               end
            end
         end else if (k == 4 + 4 * cnt) begin
            x = 8'h00;
            for (int j = 1; j < k; j++) x ^= q[j];
            if (q[k] != x) begin set_err(); return; end
            if (q[1] == 8'h02) begin
               exp_stall = 1'b0;
               exp_done  = 1'b1;
            end
         end
      end
   endtask

   function automatic bq_t make_frame(input logic [7:0] tgt, input int cnt, input bit bad);
      bq_t         q;
      logic [7:0]  x;
      logic [31:0] w;
      q.push_back(8'hA5);
      q.push_back(tgt);
      q.push_back(cnt[7:0]);
      q.push_back(cnt[15:8]);
      x = tgt ^ cnt[7:0] ^ cnt[15:8];
      for (int i = 0; i < cnt; i++) begin
         w = $urandom;
         for (int b = 0; b < 4; b++) begin
            q.push_back(w[8*b +: 8]);
            x ^= w[8*b +: 8];
         end
      end
      q.push_back(bad ? ~x : x);
      return q;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bq_t f35, frun, f, t;
      int  base;
      bit  ok;
      int  cnt;
      logic [7:0] tg;
      f35  = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h13, 8'h05, 8'h30, 8'h00,
               8'h93, 8'h05, 8'h40, 8'h00, 8'hF2};
      frun = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h02};
      exp_i_en = 1'b0;
      exp_d_en = 1'b0;
      do_reset();
      check("reset_cpu_stall", 32'(cpu_stall), 32'd1);
      check("reset_load_done", 32'(load_done), 32'd0);
      check("reset_err", 32'(err), 32'd0);
      check("reset_i_w_addr", 32'(i_w_addr), 32'd0);

      // Garbage before the header, then the reference instruction frame, gap-free and with gaps.
      for (int g = 0; g < 2; g++) begin
         base = wlog.size();
         send_byte(8'h00, 0, ok);
         send_byte(8'hFF, 0, ok);
         send_byte(8'h5A, 0, ok);
         send_frame(f35, 3 * g, 3 * g);
         step();
         check("instr_write_count", 32'(wlog.size() - base), 32'd2);
         if (wlog.size() - base == 2) begin
            check("instr_w0_port", 32'(wlog[base].port), 32'd0);
            check("instr_w0_addr", 32'(wlog[base].addr), 32'h000);
            check("instr_w0_dat", wlog[base].dat, 32'h00300513);
            check("instr_w1_addr", 32'(wlog[base+1].addr), 32'h004);
            check("instr_w1_dat", wlog[base+1].dat, 32'h00400593);
         end
         check("instr_cpu_stall", 32'(cpu_stall), 32'd1);
      end

      base = wlog.size();
      send_frame(make_frame(8'h01, 4, 1'b0), 0, 1);
      send_frame(frun, 0, 0);
      step();
      check("data_write_count", 32'(wlog.size() - base), 32'd4);
      check("data_last_addr", 32'(d_w_addr), 32'h00C);
      check("run_cpu_stall", 32'(cpu_stall), 32'd0);
      check("run_load_done", 32'(load_done), 32'd1);

      send_frame(make_frame(8'h00, 1, 1'b0), 0, 0);
      check("rerun_cpu_stall", 32'(cpu_stall), 32'd1);
      check("rerun_load_done", 32'(load_done), 32'd0);

      base = wlog.size();
      send_frame(make_frame(8'h00, 1, 1'b1), 0, 0);
      repeat (3) step();
      check("badsum_err", 32'(err), 32'd1);
      check("badsum_rx_ready", 32'(rx_ready), 32'd0);
      check("badsum_kept_write", 32'(wlog.size() - base), 32'd1);
      check("badsum_addr", 32'(i_w_addr), 32'h000);
      send_clr();
      check("clr_err", 32'(err), 32'd0);
      send_frame(make_frame(8'h01, 2, 1'b0), 0, 2);

      base = wlog.size();
      send_frame(make_frame(8'h00, 257, 1'b0), 0, 0);
      check("cnt257_err", 32'(err), 32'd1);
      send_clr();
      send_frame(make_frame(8'h03, 0, 1'b0), 0, 0);
      check("tgt3_err", 32'(err), 32'd1);
      send_clr();
      send_frame(make_frame(8'h02, 1, 1'b0), 0, 0);
      check("run_cnt1_err", 32'(err), 32'd1);
      send_clr();
      check("error_frames_no_writes", 32'(wlog.size() - base), 32'd0);

      f = make_frame(8'h00, 2, 1'b0);
      t = f[0:5];
      base = wlog.size();
      send_frame(t, 0, 0);
      do_reset();
      check("abort_no_write", 32'(wlog.size() - base), 32'd0);
      check("abort_i_w_dat", i_w_dat, 32'd0);
      send_frame(f, 0, 1);
      step();
      check("reload_count", 32'(wlog.size() - base), 32'd2);
      if (wlog.size() - base == 2) begin
         check("reload_addr0", 32'(wlog[base].addr), 32'h000);
         check("reload_dat0", wlog[base].dat, {f[7], f[6], f[5], f[4]});
      end

      send_frame(make_frame(8'h01, MAXW, 1'b0), 0, 0);
      check("max_last_addr", 32'(d_w_addr), 32'h3FC);
      check("max_err", 32'(err), 32'd0);

      for (int r = 0; r < 14; r++) begin
         cnt = int'($urandom_range(6, 0));
         tg  = 8'($urandom_range(1, 0));
         if (r % 5 == 4) begin
            tg  = 8'h02;
            cnt = 0;
         end
         send_frame(make_frame(tg, cnt, ($urandom_range(4, 0) == 0)), 0, 2);
         repeat (int'($urandom_range(2, 0))) step();
         if (exp_err) send_clr();
      end
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
